// File: rtl/gpr_serial_bank.sv
// gpr_serial_bank
// Bit-serial general-purpose register bank. It holds NREGS registers of WIDTH bits.
// A start request launches a WIDTH-cycle transfer. The transfer streams two source
// registers out LSB-first, non-destructively, and shifts one result bit per cycle
// into a destination register.
//
// Optional feature: define GPR_PARLOAD_EN to add a parallel-load port
// (i_pl_en / i_pl_addr / i_pl_data). That port is honoured only in IDLE.
//
// Handshake (start/busy): there is no ready signal. An edge on which the engine
// is IDLE and i_start=1 accepts the request and latches rs1/rs2/rd/we. While
// o_busy=1, i_start is ignored and nothing is queued. The o_done cycle is
// already IDLE, so a start raised there is accepted with no extra gap.
//
// o_state exposes the FSM state (0=IDLE, 1=SHIFT) for debug and checker binding.

module gpr_serial_bank #(
    parameter int NREGS = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(NREGS),
    localparam int BW = $clog2(WIDTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [AW-1:0]          i_rs1,
    input  logic [AW-1:0]          i_rs2,
    input  logic [AW-1:0]          i_rd,
    input  logic                   i_we,
    input  logic                   i_data_in,
`ifdef GPR_PARLOAD_EN
    input  logic                   i_pl_en,
    input  logic [AW-1:0]          i_pl_addr,
    input  logic [WIDTH-1:0]       i_pl_data,
`endif
    output logic                   o_rs1_bit,
    output logic                   o_rs2_bit,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [BW-1:0]          o_bit_idx,
    output logic [NREGS*WIDTH-1:0] o_regs,
    output logic                   o_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [BW-1:0]    cnt;
    logic [AW-1:0]    rs1_q;
    logic [AW-1:0]    rs2_q;
    logic [AW-1:0]    rd_q;
    logic             we_q;
    logic [WIDTH-1:0] regs [NREGS];

    logic             rs1_lsb;
    logic             rs2_lsb;
    logic             last_bit;

    assign last_bit = (cnt == BW'(WIDTH - 1));

    // Transfer sequencer: accept in IDLE, count WIDTH shift cycles, then pulse done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
            we_q   <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        rs1_q  <= i_rs1;
                        rs2_q  <= i_rs2;
                        rd_q   <= i_rd;
                        we_q   <= i_we;
                        cnt    <= '0;
                        state  <= SHIFT;
                        o_busy <= 1'b1;
                    end
                end
                SHIFT: begin
                    o_done <= 1'b0;
                    if (last_bit) begin
                        // Clearing the counter keeps o_bit_idx at 0 in IDLE for any WIDTH.
                        cnt    <= '0;
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else begin
                        cnt <= cnt + BW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                end
            endcase
        end
    end

    // Register file. Sources rotate right and the destination shifts in i_data_in.
    // The write overrides the rotate when rd aliases a source. Out-of-range
    // addresses never match an index, so their writes are dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                if (state == SHIFT) begin
                    if (we_q && (rd_q == AW'(k))) begin
                        regs[k] <= {i_data_in, regs[k][WIDTH-1:1]};
                    end else if ((rs1_q == AW'(k)) || (rs2_q == AW'(k))) begin
                        // rs1 == rs2 lands here once, so the register rotates once per cycle.
                        regs[k] <= {regs[k][0], regs[k][WIDTH-1:1]};
                    end
                end
`ifdef GPR_PARLOAD_EN
                else if (i_pl_en && (i_pl_addr == AW'(k))) begin
                    regs[k] <= i_pl_data;
                end
`endif
            end
        end
    end

    // Source LSB select. An address with no matching register reads as 0.
    always_comb begin
        rs1_lsb = 1'b0;
        rs2_lsb = 1'b0;
        for (int k = 0; k < NREGS; k++) begin
            if (rs1_q == AW'(k)) rs1_lsb = regs[k][0];
            if (rs2_q == AW'(k)) rs2_lsb = regs[k][0];
        end
    end

    // Serial outputs come only from registered state. They are forced low outside SHIFT.
    always_comb begin
        o_rs1_bit = (state == SHIFT) ? rs1_lsb : 1'b0;
        o_rs2_bit = (state == SHIFT) ? rs2_lsb : 1'b0;
        o_bit_idx = cnt;
        o_state   = state;
    end

    // Flatten the register array onto o_regs. Register k occupies [k*WIDTH +: WIDTH].
    always_comb begin
        o_regs = '0;
        for (int k = 0; k < NREGS; k++) begin
            o_regs[k*WIDTH +: WIDTH] = regs[k];
        end
    end

endmodule
